// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the seven-segment scan display: segment patterns,
// BCD width and the default refresh divider.
package seg7_scan_display_pkg;

  localparam int BCD_W               = 4;
  localparam int SCAN_IDX_W          = 3;
  localparam int DEFAULT_REFRESH_DIV = 100000;

  typedef logic [6:0] seg_t;

  // Active-low segment patterns ordered {g,f,e,d,c,b,a}
  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_display_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder. Codes 10..15 are
// not valid BCD and show a dash so a broken counter is visible on the board.
module bcd_to_7seg
  import seg7_scan_display_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  // Map each BCD code onto its segment pattern, dash for anything invalid
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment display driver for the Nexys A7 8-digit display.
// Scans one digit per REFRESH_DIV clocks, snapshots the digit bus at each
// frame wrap so counts rippling through the counter chain never look torn,
// and registers an/seg/dp one clock behind scan_idx.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always lit, a decimal point at or above a digit keeps it lit).
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BCD_W*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]       dp_en,
  input  logic                      disp_en,
  output logic [N_DIGITS-1:0]       an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [SCAN_IDX_W-1:0]     scan_idx,
  output logic                      frame_tick
);

  localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_IDX_W-1:0] IDX_LAST   = SCAN_IDX_W'(N_DIGITS - 1);

  logic [PRESC_W-1:0]        prescaler_q, prescaler_d;
  logic [SCAN_IDX_W-1:0]     scanIdx_q, scanIdx_d;
  logic [BCD_W*N_DIGITS-1:0] snapshot_q, snapshot_d;
  logic [N_DIGITS-1:0]       dpSnapshot_q, dpSnapshot_d;
  logic                      frameTick_q, frameTick_d;
  logic [N_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;

  logic                      slotTick;
  logic                      frameWrap;
  logic [BCD_W-1:0]          curDigit;
  logic                      curDp;
  logic [N_DIGITS-1:0]       litMask;

  // Slot timing: prescaler wraps every REFRESH_DIV clocks, scan index steps
  // per slot, and the digit/dp buses are captured on the frame wrap so
  // digit 0 of the new frame already shows fresh data
  always_comb begin
    slotTick     = (prescaler_q == PRESC_LAST);
    frameWrap    = slotTick && (scanIdx_q == IDX_LAST);
    prescaler_d  = slotTick ? '0 : prescaler_q + 1'b1;
    scanIdx_d    = scanIdx_q;
    snapshot_d   = snapshot_q;
    dpSnapshot_d = dpSnapshot_q;
    frameTick_d  = frameWrap;
    if (slotTick) begin
      scanIdx_d = frameWrap ? '0 : scanIdx_q + 1'b1;
    end
    if (frameWrap) begin
      snapshot_d   = digits;
      dpSnapshot_d = dp_en;
    end
  end

  // Pick the snapshot digit and dp request belonging to the current scan slot
  always_comb begin
    curDigit = '0;
    curDp    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (SCAN_IDX_W'(i) == scanIdx_q) begin
        curDigit = snapshot_q[i*BCD_W +: BCD_W];
        curDp    = dpSnapshot_q[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic tailActive;

  // Digit i stays lit once any digit or dp at or above it is non-zero;
  // digit 0 is always lit so a zero value still shows a single "0"
  always_comb begin
    litMask    = '1;
    tailActive = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      tailActive = tailActive | (snapshot_q[i*BCD_W +: BCD_W] != '0) | dpSnapshot_q[i];
      litMask[i] = tailActive;
    end
  end
`else
  assign litMask = '1;
`endif

  bcd_to_7seg u_decode (
    .bcd_i (curDigit),
    .seg_o (seg_d)
  );

  // Anode and dp selection; disp_en only gates the pins, scanning keeps going
  always_comb begin
    an_d = '1;
    dp_d = 1'b1;
    if (disp_en) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if ((SCAN_IDX_W'(i) == scanIdx_q) && litMask[i]) begin
          an_d[i] = 1'b0;
        end
      end
      dp_d = ~curDp;
    end
  end

  // State and output registers; reset blanks the display immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q  <= '0;
      scanIdx_q    <= '0;
      snapshot_q   <= '0;
      dpSnapshot_q <= '0;
      frameTick_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      prescaler_q  <= prescaler_d;
      scanIdx_q    <= scanIdx_d;
      snapshot_q   <= snapshot_d;
      dpSnapshot_q <= dpSnapshot_d;
      frameTick_q  <= frameTick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign scan_idx   = scanIdx_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Testbench for seg7_scan_display with N_DIGITS=8, REFRESH_DIV=4.
// Expected outputs come from an arithmetic model: edge count since reset
// gives slot and frame position directly, snapshots are taken on every
// 32nd edge. Build with LEADING_ZERO_BLANK_EN to check blanking as well.
module tb_seg7_scan_display;

  localparam int N   = 8;
  localparam int DIV = 4;
  localparam int FRAME = N * DIV;

  logic          clk;
  logic          rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]  dp_en;
  logic          disp_en;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic [2:0]    scan_idx;
  logic          frame_tick;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  // Reference model state
  int             kModel;
  logic [4*N-1:0] snapM;
  logic [N-1:0]   dpSnapM;
  logic [N-1:0]   expAn;
  logic [6:0]     expSeg;
  logic           expDp;
  logic           expFt;
  logic [2:0]     expIdx;

  logic [6:0] segTable [16];

  seg7_scan_display #(
    .N_DIGITS    (N),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_en      (dp_en),
    .disp_en    (disp_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  // 100 MHz-style clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    segTable[0]  = 7'b1000000; segTable[1]  = 7'b1111001;
    segTable[2]  = 7'b0100100; segTable[3]  = 7'b0110000;
    segTable[4]  = 7'b0011001; segTable[5]  = 7'b0010010;
    segTable[6]  = 7'b0000010; segTable[7]  = 7'b1111000;
    segTable[8]  = 7'b0000000; segTable[9]  = 7'b0010000;
    for (int i = 10; i < 16; i++) segTable[i] = 7'b0111111;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which digits may be lit: with blanking, everything up to the highest
  // non-zero digit or dp request, and always digit 0
  function automatic logic [N-1:0] litModel(input logic [4*N-1:0] s, input logic [N-1:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    int highest = 0;
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) begin
      if (s[4*i +: 4] != 4'h0 || d[i]) highest = i;
    end
    for (int i = 0; i < N; i++) m[i] = (i <= highest);
    return m;
`else
    return {N{1'b1}};
`endif
  endfunction

  function automatic logic [4*N-1:0] randomDigits();
    logic [4*N-1:0] v;
    int z;
    v = $urandom;
    z = $urandom_range(0, 8);
    for (int i = 0; i < z; i++) v[4*(7-i) +: 4] = 4'h0;
    return v;
  endfunction

  // Reference model: outputs after edge k describe the state before edge k
  always @(posedge clk or posedge rst) begin : model
    int idx;
    int k1;
    logic [N-1:0] lit;
    if (rst) begin
      kModel  <= 0;
      snapM   <= '0;
      dpSnapM <= '0;
      expAn   <= '1;
      expSeg  <= 7'h7F;
      expDp   <= 1'b1;
      expFt   <= 1'b0;
      expIdx  <= '0;
    end else begin
      idx = (kModel / DIV) % N;
      lit = litModel(snapM, dpSnapM);
      expAn  <= (disp_en && lit[idx]) ? ~(8'd1 << idx) : 8'hFF;
      expSeg <= segTable[snapM[4*idx +: 4]];
      expDp  <= disp_en ? ~dpSnapM[idx] : 1'b1;
      k1 = kModel + 1;
      kModel <= k1;
      expFt  <= (k1 % FRAME) == 0;
      if ((k1 % FRAME) == 0) begin
        snapM   <= digits;
        dpSnapM <= dp_en;
      end
      expIdx <= 3'((k1 / DIV) % N);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("an", 32'(an), 32'(expAn));
      checkOutput("dp", 32'(dp), 32'(expDp));
      checkOutput("frame_tick", 32'(frame_tick), 32'(expFt));
      checkOutput("scan_idx", 32'(scan_idx), 32'(expIdx));
      if (expAn != 8'hFF) checkOutput("seg", 32'(seg), 32'(expSeg));
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      if ($urandom_range(0, 7) == 0) digits = randomDigits();
      if ($urandom_range(0, 15) == 0)
        dp_en = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      disp_en = ($urandom_range(0, 19) != 0);
      stepCycles(1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    digits  = '0;
    dp_en   = '0;
    disp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_an", 32'(an), 32'hFF);
    checkOutput("reset_seg", 32'(seg), 32'h7F);
    checkOutput("reset_dp", 32'(dp), 32'h1);
    checkOutput("reset_ft", 32'(frame_tick), 32'h0);
    checkEn = 1'b1;

    @(negedge clk);
    digits = 32'h12345678;
    rst = 1'b0;

    stepCycles(1);
    checkOutput("first_an", 32'(an), 32'hFE);
    checkOutput("first_seg", 32'(seg), 32'b1000000);
    stepCycles(31);
    checkOutput("wrap_ft", 32'(frame_tick), 32'h1);
    checkOutput("wrap_idx", 32'(scan_idx), 32'h0);
    stepCycles(1);
    checkOutput("d0_an", 32'(an), 32'hFE);
    checkOutput("d0_seg", 32'(seg), 32'b0000000);
    stepCycles(4);
    checkOutput("d1_an", 32'(an), 32'hFD);
    checkOutput("d1_seg", 32'(seg), 32'b1111000);

    // Tearing: load 9, then change to 0x10 while slot 3 is being shown
    digits = 32'h00000009;
    stepCycles(28);
    checkOutput("nine_an", 32'(an), 32'hFE);
    checkOutput("nine_seg", 32'(seg), 32'b0010000);
    stepCycles(11);
    checkOutput("tear_idx", 32'(scan_idx), 32'h3);
    digits = 32'h00000010;
    stepCycles(21);
    checkOutput("ten_d0_an", 32'(an), 32'hFE);
    checkOutput("ten_d0_seg", 32'(seg), 32'b1000000);
    stepCycles(4);
    checkOutput("ten_d1_an", 32'(an), 32'hFD);
    checkOutput("ten_d1_seg", 32'(seg), 32'b1111001);

    // Blanking mid-frame
    stepCycles(2);
    disp_en = 1'b0;
    stepCycles(1);
    checkOutput("blank_an", 32'(an), 32'hFF);
    checkOutput("blank_dp", 32'(dp), 32'h1);
    stepCycles(5);
    disp_en = 1'b1;
    stepCycles(1);

    applyStimulus(3000);

    // Asynchronous reset in the middle of a slot
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_an", 32'(an), 32'hFF);
    checkOutput("arst_seg", 32'(seg), 32'h7F);
    checkOutput("arst_dp", 32'(dp), 32'h1);
    checkOutput("arst_ft", 32'(frame_tick), 32'h0);
    checkOutput("arst_idx", 32'(scan_idx), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(600);

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
